// File: rtl/vitals_tick_pkg.sv
// ---------------------------------------------------------------------------
// vitals_tick_pkg: FSM states, timer register map and control words. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vitals_tick_pkg;

  typedef enum logic [3:0] {
    S_STOP = 4'd0,
    S_CLR  = 4'd1,
    S_PL   = 4'd2,
    S_PH   = 4'd3,
    S_CTRL = 4'd4,
    S_IDLE = 4'd5,
    S_RD   = 4'd6,
    S_RDW  = 4'd7,
    S_ACK  = 4'd8,
    S_SCAN = 4'd9
  } state_t;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam logic [15:0] CTRL_STOP = 16'h0008;
  localparam logic [15:0] CTRL_RUN  = 16'h0007;

endpackage

`default_nettype wire

// File: rtl/vitals_tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// vitals_tick_scheduler_if: Avalon-MM link to the interval timer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vitals_tick_scheduler_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_readdata, tmr_irq
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_readdata, tmr_irq
  );
endinterface

`default_nettype wire

// File: rtl/vitals_tick_scheduler_channel.sv
// ---------------------------------------------------------------------------
// vitals_tick_channel: per-channel tick divider with registered expire pulse. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vitals_tick_channel #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             i_scan,
  input  wire logic             i_enable,
  input  wire logic [CNT_W-1:0] i_period,
  output logic                  o_expire
);

  logic [CNT_W-1:0] r_count;
  logic             r_expire;
  logic [CNT_W-1:0] w_period_eff;
  logic [CNT_W:0]   w_count_inc;
  logic             w_hit;

  // Period 0 is treated as 1; the extra compare bit keeps count+1 from wrapping.
  assign w_period_eff = (i_period == '0) ? CNT_W'(1) : i_period;
  assign w_count_inc  = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
  assign w_hit        = (w_count_inc >= {1'b0, w_period_eff});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (i_scan) begin
        if (!i_enable) begin
          r_count <= '0;
        end else if (w_hit) begin
          r_expire <= 1'b1;
          r_count  <= '0;
        end else begin
          r_count <= w_count_inc[CNT_W-1:0];
        end
      end
    end
  end

  assign o_expire = r_expire;

endmodule

`default_nettype wire

// File: rtl/vitals_tick_scheduler.sv
// ---------------------------------------------------------------------------
// vitals_tick_scheduler: programs the interval timer, services its irq and
// fans each tick out to periodic channels. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vitals_tick_scheduler
  import vitals_tick_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] DEFAULT_TICK = 32'h0001869F
) (
  input  wire logic                      clk,
  input  wire logic                      reset_n,
  vitals_tick_scheduler_if.master        tmr,
  input  wire logic                      cfg_tick_we,
  input  wire logic [31:0]               cfg_tick,
  input  wire logic [NUM_CH-1:0]         ch_enable,
  input  wire logic [NUM_CH*CNT_W-1:0]   ch_period,
  output logic      [NUM_CH-1:0]         ch_expire,
  output logic                           ready,
  output logic      [31:0]               tick_count,
  output logic      [7:0]                spurious_cnt
);

  state_t      r_state;
  state_t      w_next;
  logic        r_run;
  logic        r_ready;
  logic [31:0] r_tick_reg;
  logic [31:0] r_cfg_val;
  logic        r_cfg_pend;
  logic [31:0] r_tick_count;
  logic [7:0]  r_spur;

  logic        w_cs;
  logic        w_wn;
  logic [2:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_scan;
  logic        w_cfg_pend;
  logic [31:0] w_cfg_val;

  // A write arriving in the same cycle IDLE looks at it is taken directly.
  assign w_cfg_pend = r_cfg_pend | cfg_tick_we;
  assign w_cfg_val  = cfg_tick_we ? cfg_tick : r_cfg_val;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_STOP;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_cs    = 1'b0;
    w_wn    = 1'b1;
    w_addr  = 3'd0;
    w_wdata = 16'h0000;
    w_scan  = 1'b0;
    case (r_state)
      S_STOP: begin
        // r_run holds off the first access until a cycle out of reset.
        if (r_run) begin
          w_cs    = 1'b1;
          w_wn    = 1'b0;
          w_addr  = TMR_CONTROL;
          w_wdata = CTRL_STOP;
          w_next  = S_CLR;
        end
      end
      S_CLR: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = TMR_STATUS;
        w_next = S_PL;
      end
      S_PL: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = TMR_PERIODL;
        w_wdata = r_tick_reg[15:0];
        w_next  = S_PH;
      end
      S_PH: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = TMR_PERIODH;
        w_wdata = r_tick_reg[31:16];
        w_next  = S_CTRL;
      end
      S_CTRL: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = TMR_CONTROL;
        w_wdata = CTRL_RUN;
        w_next  = S_IDLE;
      end
      S_IDLE: begin
        if (w_cfg_pend)       w_next = S_STOP;
        else if (tmr.tmr_irq) w_next = S_RD;
      end
      S_RD: begin
        w_cs   = 1'b1;
        w_addr = TMR_STATUS;
        w_next = S_RDW;
      end
      S_RDW: begin
        w_next = tmr.tmr_readdata[0] ? S_ACK : S_IDLE;
      end
      S_ACK: begin
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_addr = TMR_STATUS;
        w_next = S_SCAN;
      end
      S_SCAN: begin
        w_scan = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_run        <= 1'b0;
      r_ready      <= 1'b0;
      r_tick_reg   <= DEFAULT_TICK;
      r_cfg_val    <= 32'h0;
      r_cfg_pend   <= 1'b0;
      r_tick_count <= 32'h0;
      r_spur       <= 8'h00;
    end else begin
      r_run   <= 1'b1;
      r_ready <= !(w_next inside {S_STOP, S_CLR, S_PL, S_PH, S_CTRL});
      if (r_state == S_IDLE && w_cfg_pend) begin
        r_tick_reg <= w_cfg_val;
        r_cfg_pend <= 1'b0;
      end else if (cfg_tick_we) begin
        r_cfg_val  <= cfg_tick;
        r_cfg_pend <= 1'b1;
      end
      if (r_state == S_RDW && !tmr.tmr_readdata[0] && r_spur != 8'hFF)
        r_spur <= r_spur + 8'd1;
      if (w_scan)
        r_tick_count <= r_tick_count + 32'd1;
    end
  end

  assign tmr.tmr_chipselect = w_cs;
  assign tmr.tmr_write_n    = w_wn;
  assign tmr.tmr_address    = w_addr;
  assign tmr.tmr_writedata  = w_wdata;

  assign ready        = r_ready;
  assign tick_count   = r_tick_count;
  assign spurious_cnt = r_spur;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    vitals_tick_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_scan   (w_scan),
      .i_enable (ch_enable[gi]),
      .i_period (ch_period[gi*CNT_W +: CNT_W]),
      .o_expire (ch_expire[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_vitals_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vitals_tick_scheduler: timer model plus event scoreboard for the scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vitals_tick_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_EXP = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        rdy;
  } ev_t;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    cfg_tick_we = 1'b0;
  logic [31:0]             cfg_tick = 32'h0;
  logic [NUM_CH-1:0]       ch_enable = '0;
  logic [NUM_CH*CNT_W-1:0] ch_period = '0;
  logic [NUM_CH-1:0]       ch_expire;
  logic                    ready;
  logic [31:0]             tick_count;
  logic [7:0]              spurious_cnt;

  logic        irq_raise = 1'b0;
  logic [15:0] tb_status = 16'h0001;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  probe_seq = 0;
  int  probe_ack = 0;
  logic [31:0] pr_tick;
  logic [7:0]  pr_spur;
  logic        pr_ready;

  vitals_tick_scheduler_if bus();

  vitals_tick_scheduler #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_TICK (32'h0001869F)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tmr          (bus),
    .cfg_tick_we  (cfg_tick_we),
    .cfg_tick     (cfg_tick),
    .ch_enable    (ch_enable),
    .ch_period    (ch_period),
    .ch_expire    (ch_expire),
    .ready        (ready),
    .tick_count   (tick_count),
    .spurious_cnt (spurious_cnt)
  );

  always #5 clk = ~clk;

  // Timer: registered readdata, irq raised on request, dropped on any status access.
  always @(posedge clk) begin
    if (!reset_n) begin
      bus.tmr_readdata <= 16'h0;
      bus.tmr_irq      <= 1'b0;
    end else begin
      bus.tmr_readdata <= (bus.tmr_chipselect && bus.tmr_write_n) ? tb_status : 16'h0;
      if (irq_raise)
        bus.tmr_irq <= 1'b1;
      else if (bus.tmr_chipselect && bus.tmr_address == 3'd0)
        bus.tmr_irq <= 1'b0;
    end
  end

  task automatic check_event(input logic [1:0] k, input logic [2:0] a,
                             input logic [15:0] d, input logic r);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h rdy=%0b, required no event",
               k, a, d, r);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || (k != K_RD && e.data != d) || e.rdy != r) begin
        n_fail++;
        $display("FAIL bus_event: got kind=%0d addr=%0d data=%h rdy=%0b, required kind=%0d addr=%0d data=%h rdy=%0b",
                 k, a, d, r, e.kind, e.addr, e.data, e.rdy);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tmr_chipselect)
      check_event(bus.tmr_write_n ? K_RD : K_WR, bus.tmr_address, bus.tmr_writedata, ready);
    if (ch_expire != '0)
      check_event(K_EXP, 3'd0, 16'(ch_expire), ready);
    if (probe_ack != probe_seq) begin
      chk("tick_count", tick_count, pr_tick);
      chk("spurious_cnt", {24'h0, spurious_cnt}, {24'h0, pr_spur});
      chk("ready", {31'h0, ready}, {31'h0, pr_ready});
      probe_ack = probe_ack + 1;
    end
  end

  task automatic push_ev(input logic [1:0] k, input logic [2:0] a,
                         input logic [15:0] d, input logic r);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.rdy = r;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic [31:0] t);
    push_ev(K_WR, 3'd1, 16'h0008, 1'b0);
    push_ev(K_WR, 3'd0, 16'h0000, 1'b0);
    push_ev(K_WR, 3'd2, t[15:0], 1'b0);
    push_ev(K_WR, 3'd3, t[31:16], 1'b0);
    push_ev(K_WR, 3'd1, 16'h0007, 1'b0);
  endtask

  task automatic push_tick(input logic [NUM_CH-1:0] pat);
    push_ev(K_RD, 3'd0, 16'h0000, 1'b1);
    push_ev(K_WR, 3'd0, 16'h0000, 1'b1);
    if (pat != '0) push_ev(K_EXP, 3'd0, 16'(pat), 1'b1);
  endtask

  task automatic pulse_irq();
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d events outstanding, required 0", exp_q.size());
      $fatal(1, "scoreboard timeout");
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic probe(input logic [31:0] t, input logic [7:0] s, input logic r);
    int k = 0;
    pr_tick  = t;
    pr_spur  = s;
    pr_ready = r;
    probe_seq++;
    while (probe_ack != probe_seq && k < 5) begin
      @(negedge clk);
      k++;
    end
    if (probe_ack != probe_seq) begin
      $display("FAIL probe_timeout: got ack %0d, required %0d", probe_ack, probe_seq);
      $fatal(1, "probe timeout");
    end
  endtask

  task automatic wait_bus(input logic want_read, input string name);
    int k = 0;
    while (!(bus.tmr_chipselect && bus.tmr_write_n == want_read && bus.tmr_address == 3'd0)
           && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      $display("FAIL %s: got no status access in 20 cycles, required one", name);
      $fatal(1, "bus wait timeout");
    end
  endtask

  logic [NUM_CH-1:0] pats [6];

  initial begin
    pats = '{4'b1001, 4'b1011, 4'b1101, 4'b1011, 4'b1001, 4'b1111};

    // Reset state, then the init sequence with the default period.
    repeat (3) @(negedge clk);
    probe(32'd0, 8'd0, 1'b0);
    push_init(32'h0001869F);
    reset_n = 1'b1;
    drain(40);
    probe(32'd0, 8'd0, 1'b1);

    // Six ticks with periods {1,2,3,0} on ch0..ch3.
    ch_period = {16'd0, 16'd3, 16'd2, 16'd1};
    ch_enable = 4'hF;
    for (int i = 0; i < 6; i++) begin
      push_tick(pats[i]);
      pulse_irq();
      drain(40);
    end
    probe(32'd6, 8'd0, 1'b1);

    // Spurious irqs: status read only, count saturates.
    tb_status = 16'h0002;
    push_ev(K_RD, 3'd0, 16'h0000, 1'b1);
    pulse_irq();
    drain(20);
    probe(32'd6, 8'd1, 1'b1);
    for (int i = 0; i < 299; i++) begin
      push_ev(K_RD, 3'd0, 16'h0000, 1'b1);
      pulse_irq();
      drain(20);
    end
    probe(32'd6, 8'd255, 1'b1);
    tb_status = 16'h0001;

    // Reprogram requested while the status read is on the bus.
    push_tick(4'b1001);
    push_init(32'h000004E1);
    pulse_irq();
    wait_bus(1'b1, "rd_wait");
    cfg_tick_we = 1'b1;
    cfg_tick    = 32'h000004E1;
    @(negedge clk);
    cfg_tick_we = 1'b0;
    drain(60);
    probe(32'd7, 8'd255, 1'b1);

    // irq and reprogram request in the same idle cycle.
    push_init(32'h00020003);
    pulse_irq();
    cfg_tick_we = 1'b1;
    cfg_tick    = 32'h00020003;
    @(negedge clk);
    cfg_tick_we = 1'b0;
    drain(40);
    probe(32'd7, 8'd255, 1'b1);

    push_tick(4'b1011);
    pulse_irq();
    drain(40);
    probe(32'd8, 8'd255, 1'b1);

    // Reset asserted during the scan cycle.
    push_ev(K_RD, 3'd0, 16'h0000, 1'b1);
    push_ev(K_WR, 3'd0, 16'h0000, 1'b1);
    pulse_irq();
    wait_bus(1'b0, "ack_wait");
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    probe(32'd0, 8'd0, 1'b0);
    push_init(32'h0001869F);
    reset_n = 1'b1;
    drain(40);
    probe(32'd0, 8'd0, 1'b1);

    // Disabled channel stays silent.
    ch_enable = 4'b0111;
    push_tick(4'b0001);
    pulse_irq();
    drain(40);
    probe(32'd1, 8'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
